// File: rtl/activation_stack_reader.sv
// rtl/activation_stack_reader.sv - backward-pass reader: walks stack layers top-down, pairs lower/higher vectors
module activation_stack_reader #(
   parameter int NEURON_NUM       = 4,
   parameter int ACTIVATION_WIDTH = 9,
   parameter int LAYER_ADDR_WIDTH = 2,
   parameter int LAYER_MAX        = 2
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [LAYER_ADDR_WIDTH-1:0]              start_layer,
   input  logic                                     start_valid,
   output logic                                     start_ready,
   output logic [LAYER_ADDR_WIDTH-1:0]              rd_addr,
   output logic                                     rd_addr_valid,
   input  logic                                     rd_addr_ready,
   input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]   lower,
   input  logic                                     lower_valid,
   output logic                                     lower_ready,
   input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]   higher,
   input  logic                                     higher_valid,
   output logic                                     higher_ready,
   output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]   pair_lower,
   output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]   pair_higher,
   output logic [LAYER_ADDR_WIDTH-1:0]              pair_layer,
   output logic                                     pair_last,
   output logic                                     pair_valid,
   input  logic                                     pair_ready,
   output logic                                     start_error
);

   localparam logic [LAYER_ADDR_WIDTH-1:0] MAX_L = LAYER_ADDR_WIDTH'(LAYER_MAX);
   localparam logic [LAYER_ADDR_WIDTH-1:0] ONE   = LAYER_ADDR_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

   state_t                        state;
   logic [LAYER_ADDR_WIDTH-1:0]   cnt;
   logic                          got_lo;
   logic                          got_hi;

   logic start_fire;
   logic start_legal;
   logic lo_fire;
   logic hi_fire;

   assign start_fire  = start_valid & start_ready;
   assign start_legal = (start_layer != '0) && (start_layer <= MAX_L);
   assign lo_fire     = lower_valid & lower_ready;
   assign hi_fire     = higher_valid & higher_ready;

   // All handshake outputs are registered; each state pre-loads the next state's outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         got_lo        <= 1'b0;
         got_hi        <= 1'b0;
         start_ready   <= 1'b0;
         rd_addr       <= '0;
         rd_addr_valid <= 1'b0;
         lower_ready   <= 1'b0;
         higher_ready  <= 1'b0;
         pair_lower    <= '0;
         pair_higher   <= '0;
         pair_layer    <= '0;
         pair_last     <= 1'b0;
         pair_valid    <= 1'b0;
         start_error   <= 1'b0;
      end else begin
         start_error <= 1'b0;
         case (state)
            IDLE: begin
               start_ready <= 1'b1;
               if (start_fire) begin
                  if (start_legal) begin
                     cnt           <= start_layer;
                     rd_addr       <= start_layer;
                     rd_addr_valid <= 1'b1;
                     start_ready   <= 1'b0;
                     state         <= ISSUE;
                  end else begin
                     start_error <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (rd_addr_ready) begin
                  rd_addr_valid <= 1'b0;
                  lower_ready   <= ~got_lo;
                  higher_ready  <= ~got_hi;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (lo_fire) begin
                  pair_lower  <= lower;
                  got_lo      <= 1'b1;
                  lower_ready <= 1'b0;
               end
               if (hi_fire) begin
                  pair_higher  <= higher;
                  got_hi       <= 1'b1;
                  higher_ready <= 1'b0;
               end
               if ((got_lo | lo_fire) && (got_hi | hi_fire)) begin
                  pair_valid <= 1'b1;
                  pair_layer <= cnt;
                  pair_last  <= (cnt == ONE);
                  state      <= EMIT;
               end
            end
            EMIT: begin
               if (pair_ready) begin
                  pair_valid <= 1'b0;
                  got_lo     <= 1'b0;
                  got_hi     <= 1'b0;
                  if (cnt == ONE) begin
                     start_ready <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     cnt           <= cnt - ONE;
                     rd_addr       <= cnt - ONE;
                     rd_addr_valid <= 1'b1;
                     state         <= ISSUE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_activation_stack_reader.sv
// tb/tb_activation_stack_reader.sv - directed bench for activation_stack_reader
module tb_activation_stack_reader;

   localparam int VW = 36;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    start_layer;
   logic          start_valid;
   logic          start_ready;
   logic [1:0]    rd_addr;
   logic          rd_addr_valid;
   logic          rd_addr_ready;
   logic [VW-1:0] lower;
   logic          lower_valid;
   logic          lower_ready;
   logic [VW-1:0] higher;
   logic          higher_valid;
   logic          higher_ready;
   logic [VW-1:0] pair_lower;
   logic [VW-1:0] pair_higher;
   logic [1:0]    pair_layer;
   logic          pair_last;
   logic          pair_valid;
   logic          pair_ready;
   logic          start_error;

   int checks = 0;
   int errors = 0;

   localparam logic [VW-1:0] V0  = 36'h0_1234_5678;
   localparam logic [VW-1:0] V1  = 36'hA_BCDE_F012;
   localparam logic [VW-1:0] V2  = 36'h5_5AA5_3C3C;
   localparam logic [VW-1:0] BAD = 36'hF_FFFF_0000;

   activation_stack_reader dut (
      .clk(clk), .rst(rst),
      .start_layer(start_layer), .start_valid(start_valid), .start_ready(start_ready),
      .rd_addr(rd_addr), .rd_addr_valid(rd_addr_valid), .rd_addr_ready(rd_addr_ready),
      .lower(lower), .lower_valid(lower_valid), .lower_ready(lower_ready),
      .higher(higher), .higher_valid(higher_valid), .higher_ready(higher_ready),
      .pair_lower(pair_lower), .pair_higher(pair_higher), .pair_layer(pair_layer),
      .pair_last(pair_last), .pair_valid(pair_valid), .pair_ready(pair_ready),
      .start_error(start_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [1:0] t);
      start_layer = t;
      start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
   endtask

   // Entered at a negedge with the address for layer l already presented.
   task automatic run_layer(input logic [1:0] l, input logic [VW-1:0] lo, input logic [VW-1:0] hi,
                            input logic last);
      chk("addr_valid", 64'(rd_addr_valid), 64'd1);
      chk("addr", 64'(rd_addr), 64'(l));
      rd_addr_ready = 1'b1;
      @(negedge clk);
      rd_addr_ready = 1'b0;
      chk("wait_addr_valid", 64'(rd_addr_valid), 64'd0);
      chk("wait_lower_ready", 64'(lower_ready), 64'd1);
      chk("wait_higher_ready", 64'(higher_ready), 64'd1);
      lower = lo; higher = hi; lower_valid = 1'b1; higher_valid = 1'b1;
      @(negedge clk);
      lower_valid = 1'b0; higher_valid = 1'b0;
      chk("pair_valid", 64'(pair_valid), 64'd1);
      chk("pair_layer", 64'(pair_layer), 64'(l));
      chk("pair_last", 64'(pair_last), 64'(last));
      chk("pair_lower", 64'(pair_lower), 64'(lo));
      chk("pair_higher", 64'(pair_higher), 64'(hi));
      chk("emit_lower_ready", 64'(lower_ready), 64'd0);
      pair_ready = 1'b1;
      @(negedge clk);
      pair_ready = 1'b0;
      chk("pair_taken", 64'(pair_valid), 64'd0);
   endtask

   initial begin
      rst = 1'b0;
      start_layer = 2'd2; start_valid = 1'b1;
      rd_addr_ready = 1'b0; pair_ready = 1'b0;
      lower = '0; higher = '0; lower_valid = 1'b0; higher_valid = 1'b0;

      // 1: reset held with a start token pending
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_start_ready", 64'(start_ready), 64'd0);
         chk("rst_addr_valid", 64'(rd_addr_valid), 64'd0);
         chk("rst_pair_valid", 64'(pair_valid), 64'd0);
      end
      start_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_start_ready", 64'(start_ready), 64'd1);
      chk("post_rst_error", 64'(start_error), 64'd0);

      // 2: T=2 full sweep, stack answers one cycle after address
      start(2'd2);
      chk("busy_start_ready", 64'(start_ready), 64'd0);
      run_layer(2'd2, V1, V2, 1'b0);
      run_layer(2'd1, V0, V1, 1'b1);
      chk("idle_after_7", 64'(start_ready), 64'd1);
      chk("idle_addr_valid", 64'(rd_addr_valid), 64'd0);

      // 3: higher arrives three cycles before lower
      start(2'd2);
      rd_addr_ready = 1'b1;
      @(negedge clk);
      rd_addr_ready = 1'b0;
      higher = V2; higher_valid = 1'b1;
      @(negedge clk);
      chk("hi_only_higher_ready", 64'(higher_ready), 64'd0);
      chk("hi_only_lower_ready", 64'(lower_ready), 64'd1);
      chk("hi_only_pair_valid", 64'(pair_valid), 64'd0);
      higher = BAD;
      @(negedge clk);
      @(negedge clk);
      chk("hi_wait_pair_valid", 64'(pair_valid), 64'd0);
      lower = V1; lower_valid = 1'b1;
      @(negedge clk);
      lower_valid = 1'b0; higher_valid = 1'b0;
      chk("ooo_pair_valid", 64'(pair_valid), 64'd1);
      chk("ooo_pair_higher", 64'(pair_higher), 64'(V2));
      chk("ooo_pair_lower", 64'(pair_lower), 64'(V1));
      chk("ooo_pair_layer", 64'(pair_layer), 64'd2);

      // 4: back-pressure holds EMIT
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_pair_valid", 64'(pair_valid), 64'd1);
         chk("bp_pair_higher", 64'(pair_higher), 64'(V2));
         chk("bp_pair_lower", 64'(pair_lower), 64'(V1));
         chk("bp_pair_last", 64'(pair_last), 64'd0);
         chk("bp_addr_valid", 64'(rd_addr_valid), 64'd0);
      end
      pair_ready = 1'b1;
      @(negedge clk);
      pair_ready = 1'b0;
      run_layer(2'd1, V2, V0, 1'b1);
      chk("idle_after_bp", 64'(start_ready), 64'd1);

      // 5: illegal start layers
      start(2'd0);
      chk("err_t0", 64'(start_error), 64'd1);
      chk("err_t0_addr_valid", 64'(rd_addr_valid), 64'd0);
      chk("err_t0_idle", 64'(start_ready), 64'd1);
      @(negedge clk);
      chk("err_t0_pulse", 64'(start_error), 64'd0);
      start(2'd3);
      chk("err_t3", 64'(start_error), 64'd1);
      chk("err_t3_addr_valid", 64'(rd_addr_valid), 64'd0);
      @(negedge clk);
      chk("err_t3_pulse", 64'(start_error), 64'd0);
      chk("err_t3_addr_valid2", 64'(rd_addr_valid), 64'd0);
      chk("err_t3_idle", 64'(start_ready), 64'd1);

      // 6: reset in WAIT with lower captured, then T=1 sweep
      start(2'd2);
      rd_addr_ready = 1'b1;
      @(negedge clk);
      rd_addr_ready = 1'b0;
      lower = V1; lower_valid = 1'b1;
      @(negedge clk);
      lower_valid = 1'b0;
      chk("got_lo_lower_ready", 64'(lower_ready), 64'd0);
      chk("got_lo_higher_ready", 64'(higher_ready), 64'd1);
      rst = 1'b0;
      #1;
      chk("async_rst_higher_ready", 64'(higher_ready), 64'd0);
      chk("async_rst_start_ready", 64'(start_ready), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst6_start_ready", 64'(start_ready), 64'd1);
      chk("rst6_pair_valid", 64'(pair_valid), 64'd0);
      start(2'd1);
      run_layer(2'd1, V0, V2, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t1_no_more_pairs", 64'(pair_valid), 64'd0);
         chk("t1_no_more_addr", 64'(rd_addr_valid), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
